// File: rtl/reg_write_demux_if.sv
// Write-request channel for reg_write_demux: valid/ready handshake carrying a
// target register index and the value to store.
//   valid : request present (master -> slave)
//   ready : slave can take the request this edge (slave -> master)
//   addr  : target register index
//   data  : value to write
interface reg_write_demux_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/reg_write_demux.sv
// Write side of the register file. Write requests arrive on a valid/ready channel,
// are buffered in a small FIFO, and the head entry is committed to one register via a
// one-hot decode whenever commit_en allows. The flat q vector feeds the read muxes.
//
// Ports:
//   clk          : clock, all state updates on the rising edge
//   rst          : asynchronous reset, active-high
//   wr           : write-request channel (slave side: valid/ready/addr/data)
//   commit_en    : allow the head-of-FIFO entry to commit this cycle
//   q            : register contents, reg i at q[i*DATA_W +: DATA_W]
//   wr_done      : one-cycle pulse, a write committed on the last edge
//   wr_done_addr : address of the write flagged by wr_done
//   wr_err       : one-cycle pulse, head entry dropped because addr >= NUM_REGS
//   busy         : FIFO non-empty
//
// Build option: define REGWR_R0_ZERO_EN to hardwire register 0 to zero. Commits to
// address 0 still pop the entry and pulse wr_done.
module reg_write_demux #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  reg_write_demux_if.slave           wr,
  input  logic                       commit_en,
  output logic [NUM_REGS*DATA_W-1:0] q,
  output logic                       wr_done,
  output logic [ADDR_W-1:0]          wr_done_addr,
  output logic                       wr_err,
  output logic                       busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              head_ok;
  logic [NUM_REGS-1:0] we;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_done_q, wr_err_q;
  logic [ADDR_W-1:0] wr_done_addr_q;

  // Ready depends only on registered occupancy, so a full FIFO that pops this cycle
  // still refuses the incoming request until the next cycle.
  assign wr.ready  = ~rst & (count_q != CntW'(FIFO_DEPTH));
  assign push      = wr.valid & wr.ready;
  assign pop       = commit_en & (count_q != '0);
  assign head_addr = addr_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];
  assign head_ok   = 32'(head_addr) < NUM_REGS;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // One-hot write enable from the head address; out-of-range heads enable nothing.
  always_comb begin
    we = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      we[i] = pop & head_ok & (32'(head_addr) == i);
    end
`ifdef REGWR_R0_ZERO_EN
    we[0] = 1'b0;
`endif
  end

  // Storage slots need no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr.addr;
      data_mem[wr_ptr_q] <= wr.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wr_done_q      <= 1'b0;
      wr_err_q       <= 1'b0;
      wr_done_addr_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_done_q <= pop & head_ok;
      wr_err_q  <= pop & ~head_ok;
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (pop & head_ok) wr_done_addr_q <= head_addr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (we[i]) regs_q[i] <= head_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
    assign q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign wr_done      = wr_done_q;
  assign wr_done_addr = wr_done_addr_q;
  assign wr_err       = wr_err_q;
  assign busy         = count_q != '0;

endmodule
